// File: rtl/shift_unit_iter_pkg.sv
// Shared encodings for the iterative shifter: shift opcodes, FSM states and
// the per-cycle step clamp.
package shift_unit_iter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_RSV = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        SHU_IDLE = 2'b00,
        SHU_RUN  = 2'b01,
        SHU_DONE = 2'b10
    } shu_state_e;

    // Wide enough to hold a step count of 0..4.
    localparam int unsigned SHU_STEP_W = 3;

    // Bits to shift this cycle: STEP, or the remainder when fewer are left.
    function automatic logic [SHU_STEP_W-1:0] shu_clamp_step(
        input logic [4:0]  rem,
        input int unsigned step
    );
        return (rem < 5'(step)) ? rem[SHU_STEP_W-1:0] : SHU_STEP_W'(step);
    endfunction

endpackage

// File: rtl/shift_unit_iter_step.sv
// One iteration of the shifter: shifts by n (0..STEP) with the fill that
// matches the operation; the reserved opcode passes the value through.
module shift_step_comb
    import shift_unit_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]      shreg,
    input  shift_op_e             op,
    input  logic [SHU_STEP_W-1:0] n,
    output logic [WIDTH-1:0]      shifted
);

    always_comb begin
        shifted = shreg;
        case (op)
            SHIFT_SLL: shifted = shreg << n;
            SHIFT_SRL: shifted = shreg >> n;
            SHIFT_SRA: shifted = WIDTH'($signed(shreg) >>> n);
            default:   shifted = shreg;
        endcase
    end

endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle SLL/SRL/SRA unit shifting STEP bits per clock under a
// start/busy/done handshake; keeps the barrel shifter off the ALU path.
module shift_unit_iter
    import shift_unit_iter_pkg::*;
#(
    parameter int unsigned STEP  = 1,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [31:0]      shamt32,
    input  logic [WIDTH-1:0] data_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    if (!(STEP == 1 || STEP == 2 || STEP == 4)) begin : g_bad_step
        $error("shift_unit_iter: STEP must be 1, 2 or 4");
    end

    shu_state_e              state_q;
    shift_op_e               op_q;
    logic [4:0]              rem_q;
    logic [WIDTH-1:0]        shreg_q;
    logic [WIDTH-1:0]        result_q;
    logic                    done_q;

    logic [SHU_STEP_W-1:0]   n_d;
    logic [WIDTH-1:0]        shreg_d;

    assign n_d = shu_clamp_step(rem_q, STEP);

    shift_step_comb #(.WIDTH(WIDTH)) u_step (
        .shreg   (shreg_q),
        .op      (op_q),
        .n       (n_d),
        .shifted (shreg_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SHU_IDLE;
            op_q     <= SHIFT_SLL;
            rem_q    <= '0;
            shreg_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                SHU_IDLE, SHU_DONE: begin
                    // DONE accepts a new start directly so back-to-back ops see no idle gap.
                    if (start) begin
                        shreg_q <= data_in;
                        op_q    <= shift_op_e'(op);
                        rem_q   <= (op == SHIFT_RSV) ? 5'd0 : shamt32[4:0];
                        state_q <= SHU_RUN;
                    end else begin
                        state_q <= SHU_IDLE;
                    end
                end
                SHU_RUN: begin
                    if (flush) begin
                        state_q <= SHU_IDLE;
                    end else if (rem_q != 5'd0) begin
                        shreg_q <= shreg_d;
                        rem_q   <= rem_q - 5'(n_d);
                    end else begin
                        result_q <= shreg_q;
                        done_q   <= 1'b1;
                        state_q  <= SHU_DONE;
                    end
                end
                default: state_q <= SHU_IDLE;
            endcase
        end
    end

    assign busy   = (state_q == SHU_RUN);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed bench for shift_unit_iter: STEP=1 and STEP=4 instances share the
// stimulus and are checked against hand-computed results and latencies.
module tb_shift_unit_iter;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        start   = 1'b0;
    logic        flush   = 1'b0;
    logic [1:0]  op      = 2'b00;
    logic [31:0] shamt32 = '0;
    logic [31:0] data_in = '0;

    logic        busy1, done1, busy4, done4;
    logic [31:0] res1, res4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_unit_iter #(.STEP(1), .WIDTH(32)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .shamt32 (shamt32),
        .data_in (data_in),
        .flush   (flush),
        .busy    (busy1),
        .done    (done1),
        .result  (res1)
    );

    shift_unit_iter #(.STEP(4), .WIDTH(32)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .shamt32 (shamt32),
        .data_in (data_in),
        .flush   (flush),
        .busy    (busy4),
        .done    (done4),
        .result  (res4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Launch one op on both instances; record the edge of the first done and
    // the number of done cycles over a bounded window.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                          input logic [31:0] a, input logic [31:0] r,
                          input int lat1, input int lat4, input bit glitch);
        int seen1, seen4, nd1, nd4, win;
        seen1 = 0; seen4 = 0; nd1 = 0; nd4 = 0;
        win = ((lat1 > lat4) ? lat1 : lat4) + 3;
        @(negedge clk);
        op = o; data_in = d; shamt32 = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ":busy1"}, {31'b0, busy1}, 32'd1);
        check({tag, ":busy4"}, {31'b0, busy4}, 32'd1);
        for (int k = 1; k <= win; k++) begin
            if (glitch && k == 2) begin
                start = 1'b1; op = 2'b00; data_in = '1; shamt32 = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done1) begin nd1++; if (seen1 == 0) seen1 = k; end
            if (done4) begin nd4++; if (seen4 == 0) seen4 = k; end
        end
        start = 1'b0;
        check({tag, ":res1"}, res1, r);
        check({tag, ":res4"}, res4, r);
        check({tag, ":lat1"}, 32'(seen1), 32'(lat1));
        check({tag, ":lat4"}, 32'(seen4), 32'(lat4));
        check({tag, ":ndone1"}, 32'(nd1), 32'd1);
        check({tag, ":ndone4"}, 32'(nd4), 32'd1);
    endtask

    initial begin
        int nd;

        #1 rst = 1'b1;
        #1;
        check("rst:busy1", {31'b0, busy1}, 32'd0);
        check("rst:done1", {31'b0, done1}, 32'd0);
        check("rst:res1",  res1, 32'd0);
        check("rst:busy4", {31'b0, busy4}, 32'd0);
        check("rst:done4", {31'b0, done4}, 32'd0);
        check("rst:res4",  res4, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("sll31",   2'b00, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32, 9, 1'b0);
        run_op("sra4",    2'b10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5, 2, 1'b0);
        run_op("srl_hi",  2'b01, 32'hF000_0000, 32'hFFFF_FFE4, 32'h0F00_0000, 5, 2, 1'b0);
        run_op("zero",    2'b00, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1, 1, 1'b0);
        run_op("rsv",     2'b11, 32'h1234_5678, 32'h0000_0005, 32'h1234_5678, 1, 1, 1'b0);
        run_op("sra16",   2'b10, 32'h8000_0001, 32'hFFFF_FFF0, 32'hFFFF_8000, 17, 5, 1'b0);
        run_op("sra_pos", 2'b10, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 32, 9, 1'b0);
        run_op("srl31",   2'b01, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 32, 9, 1'b0);
        run_op("sra3",    2'b10, 32'h8000_0000, 32'h0000_0003, 32'hF000_0000, 4, 2, 1'b0);
        run_op("glitch",  2'b01, 32'h0000_0100, 32'h0000_0008, 32'h0000_0001, 9, 3, 1'b1);

        // Back-to-back: second start issued in the DONE cycle.
        @(negedge clk);
        op = 2'b00; data_in = 32'hA5A5_A5A5; shamt32 = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b:done1a", {31'b0, done1}, 32'd1);
        check("b2b:done4a", {31'b0, done4}, 32'd1);
        check("b2b:res1a",  res1, 32'hA5A5_A5A5);
        op = 2'b01; data_in = 32'h0BAD_F00D; shamt32 = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b:busy1", {31'b0, busy1}, 32'd1);
        check("b2b:busy4", {31'b0, busy4}, 32'd1);
        check("b2b:hold1", res1, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        check("b2b:done1b", {31'b0, done1}, 32'd1);
        check("b2b:res1b",  res1, 32'h0BAD_F00D);
        check("b2b:res4b",  res4, 32'h0BAD_F00D);
        repeat (3) @(posedge clk);

        // Flush during the third RUN cycle.
        @(negedge clk);
        op = 2'b00; data_in = 32'h0000_0001; shamt32 = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush:busy1", {31'b0, busy1}, 32'd0);
        check("flush:busy4", {31'b0, busy4}, 32'd0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done1 || done4) nd++;
        end
        check("flush:ndone", 32'(nd), 32'd0);
        check("flush:res1", res1, 32'h0BAD_F00D);
        check("flush:res4", res4, 32'h0BAD_F00D);

        // Asynchronous reset mid-RUN, sampled before any further clock edge.
        @(negedge clk);
        op = 2'b00; data_in = 32'h0000_0001; shamt32 = 32'd31; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("arst:pre_busy1", {31'b0, busy1}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst:busy1", {31'b0, busy1}, 32'd0);
        check("arst:done1", {31'b0, done1}, 32'd0);
        check("arst:res1",  res1, 32'd0);
        check("arst:busy4", {31'b0, busy4}, 32'd0);
        check("arst:done4", {31'b0, done4}, 32'd0);
        check("arst:res4",  res4, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("post", 2'b00, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 2, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
